// File: rtl/letc_core_stage_f2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | letc_core_stage_f2 : fetch stage 2, one outstanding icache request    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module letc_core_stage_f2 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_f1_valid,
  input  logic [29:0] i_f1_pc_word,
  input  logic [33:0] i_f1_fetch_addr,
  output logic        o_stage_ready,
  input  logic        i_stage_flush,
  input  logic        i_stage_stall,
  output logic        o_ic_req_valid,
  input  logic        i_ic_req_ready,
  output logic [33:0] o_ic_req_addr,
  input  logic        i_ic_rsp_valid,
  input  logic [31:0] i_ic_rsp_instr,
  input  logic        i_ic_rsp_fault,
  output logic        o_f2_to_d_valid,
  output logic [29:0] o_f2_to_d_pc_word,
  output logic [31:0] o_f2_to_d_instr,
  output logic        o_f2_to_d_fault,
  input  logic        i_d_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [29:0] pc_word;
  logic [33:0] fetch_addr;
  logic [31:0] instr;
  logic        fault;
  logic        stage_ready;
  logic        accept;
  logic        capture;

  always_comb begin
    stage_ready = 1'b0;
    if (!i_stage_stall && !i_stage_flush) begin
      stage_ready = (state == IDLE) || ((state == HOLD) && i_d_ready);
    end
  end

  assign accept  = i_f1_valid && stage_ready;
  assign capture = (state == WAIT) && i_ic_rsp_valid && !i_stage_flush;

  always_comb begin
    next_state = state;
    if (i_stage_flush) begin
      unique case (state)
        IDLE:    next_state = IDLE;
        HOLD:    next_state = IDLE;
        REQ:     next_state = i_ic_req_ready ? DRAIN : IDLE;
        WAIT:    next_state = i_ic_rsp_valid ? IDLE : DRAIN;
        DRAIN:   next_state = DRAIN;
        default: next_state = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE:    if (accept) next_state = REQ;
        REQ:     if (i_ic_req_ready) next_state = WAIT;
        WAIT:    if (i_ic_rsp_valid) next_state = HOLD;
        // Handoff only when unstalled; a same-cycle accept chains straight to REQ.
        HOLD:    if (i_d_ready && !i_stage_stall) next_state = accept ? REQ : IDLE;
        DRAIN:   if (i_ic_rsp_valid) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      pc_word    <= '0;
      fetch_addr <= '0;
      instr      <= '0;
      fault      <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        pc_word    <= i_f1_pc_word;
        fetch_addr <= i_f1_fetch_addr;
      end
      if (capture) begin
        instr <= i_ic_rsp_instr;
        fault <= i_ic_rsp_fault;
      end
    end
  end

  assign o_stage_ready     = stage_ready;
  assign o_ic_req_valid    = (state == REQ);
  assign o_ic_req_addr     = fetch_addr;
  assign o_f2_to_d_valid   = (state == HOLD);
  assign o_f2_to_d_pc_word = pc_word;
  assign o_f2_to_d_instr   = instr;
  assign o_f2_to_d_fault   = fault;

endmodule
`default_nettype wire

// File: tb/tb_letc_core_stage_f2.sv
`default_nettype none
// Directed self-checking bench for letc_core_stage_f2.
module tb_letc_core_stage_f2;

  logic        clk = 1'b0;
  logic        rst;
  logic        f1_valid;
  logic [29:0] f1_pc_word;
  logic [33:0] f1_fetch_addr;
  logic        stage_ready;
  logic        stage_flush;
  logic        stage_stall;
  logic        ic_req_valid;
  logic        ic_req_ready;
  logic [33:0] ic_req_addr;
  logic        ic_rsp_valid;
  logic [31:0] ic_rsp_instr;
  logic        ic_rsp_fault;
  logic        d_valid;
  logic [29:0] d_pc_word;
  logic [31:0] d_instr;
  logic        d_fault;
  logic        d_ready;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  letc_core_stage_f2 dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_f1_valid        (f1_valid),
    .i_f1_pc_word      (f1_pc_word),
    .i_f1_fetch_addr   (f1_fetch_addr),
    .o_stage_ready     (stage_ready),
    .i_stage_flush     (stage_flush),
    .i_stage_stall     (stage_stall),
    .o_ic_req_valid    (ic_req_valid),
    .i_ic_req_ready    (ic_req_ready),
    .o_ic_req_addr     (ic_req_addr),
    .i_ic_rsp_valid    (ic_rsp_valid),
    .i_ic_rsp_instr    (ic_rsp_instr),
    .i_ic_rsp_fault    (ic_rsp_fault),
    .o_f2_to_d_valid   (d_valid),
    .o_f2_to_d_pc_word (d_pc_word),
    .o_f2_to_d_instr   (d_instr),
    .o_f2_to_d_fault   (d_fault),
    .i_d_ready         (d_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; f1_valid = 1'b0; f1_pc_word = '0; f1_fetch_addr = '0;
    stage_flush = 1'b0; stage_stall = 1'b0; ic_req_ready = 1'b0;
    ic_rsp_valid = 1'b0; ic_rsp_instr = '0; ic_rsp_fault = 1'b0; d_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; settle();
    check("rst_ready", 64'(stage_ready), 64'd1);
    check("rst_req_valid", 64'(ic_req_valid), 64'd0);
    check("rst_d_valid", 64'(d_valid), 64'd0);
    check("rst_addr", 64'(ic_req_addr), 64'd0);
    check("rst_pc", 64'(d_pc_word), 64'd0);
    check("rst_instr", 64'(d_instr), 64'd0);

    // Stall in IDLE blocks accept
    stage_stall = 1'b1; f1_valid = 1'b1; f1_pc_word = 30'h0777; f1_fetch_addr = 34'h1DDC;
    settle();
    check("idle_stall_ready", 64'(stage_ready), 64'd0);
    tick();
    stage_stall = 1'b0; f1_valid = 1'b0; settle();
    check("idle_stall_no_req", 64'(ic_req_valid), 64'd0);
    check("idle_stall_ready_back", 64'(stage_ready), 64'd1);

    // Basic fetch: accept, REQ, WAIT, HOLD
    f1_valid = 1'b1; f1_pc_word = 30'h1000; f1_fetch_addr = 34'h4000; settle();
    check("s1_accept_ready", 64'(stage_ready), 64'd1);
    tick();
    f1_valid = 1'b0; ic_req_ready = 1'b1; settle();
    check("s1_req_valid", 64'(ic_req_valid), 64'd1);
    check("s1_req_addr", 64'(ic_req_addr), 64'h4000);
    check("s1_req_ready_out", 64'(stage_ready), 64'd0);
    check("s1_req_d_valid", 64'(d_valid), 64'd0);
    tick();
    ic_req_ready = 1'b0; ic_rsp_valid = 1'b1; ic_rsp_instr = 32'h00000013; settle();
    check("s1_wait_req_valid", 64'(ic_req_valid), 64'd0);
    check("s1_wait_d_valid", 64'(d_valid), 64'd0);
    tick();
    ic_rsp_valid = 1'b0; ic_rsp_instr = '0; settle();
    check("s1_hold_valid", 64'(d_valid), 64'd1);
    check("s1_hold_pc", 64'(d_pc_word), 64'h1000);
    check("s1_hold_instr", 64'(d_instr), 64'h00000013);
    check("s1_hold_fault", 64'(d_fault), 64'd0);
    check("s1_hold_ready_nodr", 64'(stage_ready), 64'd0);

    // Back-to-back: second accept in the handoff cycle
    d_ready = 1'b1; f1_valid = 1'b1; f1_pc_word = 30'h1001; f1_fetch_addr = 34'h4004; settle();
    check("s2_handoff_ready", 64'(stage_ready), 64'd1);
    tick();
    d_ready = 1'b0; f1_valid = 1'b0; settle();
    check("s2_req_valid", 64'(ic_req_valid), 64'd1);
    check("s2_req_addr", 64'(ic_req_addr), 64'h4004);
    check("s2_d_valid_gone", 64'(d_valid), 64'd0);
    ic_req_ready = 1'b1;
    tick();
    ic_req_ready = 1'b0; ic_rsp_valid = 1'b1; ic_rsp_instr = 32'h00100093;
    tick();
    ic_rsp_valid = 1'b0; settle();
    check("s2_hold_pc", 64'(d_pc_word), 64'h1001);
    check("s2_hold_instr", 64'(d_instr), 64'h00100093);

    // Stall in HOLD for 4 cycles with decode ready
    stage_stall = 1'b1; d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("s5_stall_ready", 64'(stage_ready), 64'd0);
      check("s5_stall_valid", 64'(d_valid), 64'd1);
      check("s5_stall_pc", 64'(d_pc_word), 64'h1001);
      check("s5_stall_instr", 64'(d_instr), 64'h00100093);
      tick();
    end
    stage_stall = 1'b0; settle();
    check("s5_unstall_ready", 64'(stage_ready), 64'd1);
    tick();
    d_ready = 1'b0; settle();
    check("s5_idle_valid", 64'(d_valid), 64'd0);
    check("s5_idle_ready", 64'(stage_ready), 64'd1);

    // Response in IDLE is ignored
    ic_rsp_valid = 1'b1; ic_rsp_instr = 32'hCAFEF00D;
    tick();
    ic_rsp_valid = 1'b0; settle();
    check("idle_rsp_d_valid", 64'(d_valid), 64'd0);
    check("idle_rsp_instr", 64'(d_instr), 64'h00100093);

    // Flush in WAIT without response, response arrives 2 cycles later
    f1_valid = 1'b1; f1_pc_word = 30'h2000; f1_fetch_addr = 34'h8000;
    tick();
    f1_valid = 1'b0; ic_req_ready = 1'b1;
    tick();
    ic_req_ready = 1'b0; stage_flush = 1'b1; settle();
    check("s3_flush_ready", 64'(stage_ready), 64'd0);
    tick();
    stage_flush = 1'b0; settle();
    check("s3_drain_ready", 64'(stage_ready), 64'd0);
    check("s3_drain_req", 64'(ic_req_valid), 64'd0);
    tick();
    ic_rsp_valid = 1'b1; ic_rsp_instr = 32'hDEADBEEF; settle();
    check("s3_drain_ready2", 64'(stage_ready), 64'd0);
    tick();
    ic_rsp_valid = 1'b0; settle();
    check("s3_idle_ready", 64'(stage_ready), 64'd1);
    check("s3_no_d_valid", 64'(d_valid), 64'd0);
    check("s3_instr_kept", 64'(d_instr), 64'h00100093);

    // Flush coincident with req_ready in REQ -> DRAIN
    f1_valid = 1'b1; f1_pc_word = 30'h3000; f1_fetch_addr = 34'hC000;
    tick();
    f1_valid = 1'b0; stage_flush = 1'b1; ic_req_ready = 1'b1;
    tick();
    stage_flush = 1'b0; ic_req_ready = 1'b0; settle();
    check("s4_drain_req", 64'(ic_req_valid), 64'd0);
    check("s4_drain_ready", 64'(stage_ready), 64'd0);
    ic_rsp_valid = 1'b1; ic_rsp_instr = 32'h11111111;
    tick();
    ic_rsp_valid = 1'b0; settle();
    check("s4_idle_ready", 64'(stage_ready), 64'd1);
    check("s4_no_d_valid", 64'(d_valid), 64'd0);

    // Flush in REQ without req_ready -> IDLE directly
    f1_valid = 1'b1; f1_pc_word = 30'h3100; f1_fetch_addr = 34'hC400;
    tick();
    f1_valid = 1'b0; stage_flush = 1'b1;
    tick();
    stage_flush = 1'b0; settle();
    check("freq_idle_ready", 64'(stage_ready), 64'd1);
    check("freq_req_valid", 64'(ic_req_valid), 64'd0);

    // Flush in WAIT with coincident response -> IDLE, response dropped
    f1_valid = 1'b1; f1_pc_word = 30'h3200; f1_fetch_addr = 34'hC800;
    tick();
    f1_valid = 1'b0; ic_req_ready = 1'b1;
    tick();
    ic_req_ready = 1'b0; stage_flush = 1'b1; ic_rsp_valid = 1'b1; ic_rsp_instr = 32'h22222222;
    tick();
    stage_flush = 1'b0; ic_rsp_valid = 1'b0; settle();
    check("fwait_idle_ready", 64'(stage_ready), 64'd1);
    check("fwait_d_valid", 64'(d_valid), 64'd0);
    check("fwait_instr_kept", 64'(d_instr), 64'h00100093);

    // Max-width fields, fault response, then reset while in HOLD
    f1_valid = 1'b1; f1_pc_word = 30'h3FFFFFFF; f1_fetch_addr = 34'h3FFFFFFFC;
    tick();
    f1_valid = 1'b0; ic_req_ready = 1'b1; settle();
    check("s6_req_addr", 64'(ic_req_addr), 64'h3FFFFFFFC);
    tick();
    ic_req_ready = 1'b0; ic_rsp_valid = 1'b1; ic_rsp_instr = 32'hFFFFFFFF; ic_rsp_fault = 1'b1;
    tick();
    ic_rsp_valid = 1'b0; ic_rsp_fault = 1'b0; settle();
    check("s6_hold_fault", 64'(d_fault), 64'd1);
    check("s6_hold_pc", 64'(d_pc_word), 64'h3FFFFFFF);
    check("s6_hold_instr", 64'(d_instr), 64'hFFFFFFFF);
    rst = 1'b1; stage_flush = 1'b1; stage_stall = 1'b1;
    tick();
    rst = 1'b0; stage_flush = 1'b0; stage_stall = 1'b0; settle();
    check("s6_rst_d_valid", 64'(d_valid), 64'd0);
    check("s6_rst_fault", 64'(d_fault), 64'd0);
    check("s6_rst_pc", 64'(d_pc_word), 64'd0);
    check("s6_rst_instr", 64'(d_instr), 64'd0);
    check("s6_rst_addr", 64'(ic_req_addr), 64'd0);
    check("s6_rst_req_valid", 64'(ic_req_valid), 64'd0);
    check("s6_rst_ready", 64'(stage_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
